// File: rtl/onchipalarm_pio_edge.sv
// Avalon-MM edge-capture PIO: synchronised inputs, per-bit edge capture with
// write-one-to-clear, interrupt mask, level irq and registered readback.
module onchipalarm_pio_edge #(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     data_sync;
  logic [WIDTH-1:0]     data_dly_q;
  logic                 armed_q;
  logic [SYNC_STAGES:1] valid_q;
  logic [WIDTH-1:0]     edgecap_q;
  logic [WIDTH-1:0]     edgecap_d;
  logic [WIDTH-1:0]     irqmask_q;
  logic [WIDTH-1:0]     irqmask_d;
  logic [31:0]          readdata_q;
  logic [31:0]          readdata_d;
  logic [WIDTH-1:0]     edge_s;
  logic [WIDTH-1:0]     clr_s;
  logic                 wr_s;
  logic                 detect_en_s;

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign wr_s      = chipselect & ~write_n;

  // valid_q tracks how far real post-reset samples have travelled down the
  // pipeline, so the zeros left behind by reset never look like an edge.
  assign detect_en_s = armed_q & valid_q[SYNC_STAGES];

  // Edge detection on the synchronised input, gated until data_dly is real
  always_comb begin
    edge_s = '0;
    if (detect_en_s) begin
      case (EDGE_TYPE)
        EDGE_RISE: edge_s = data_sync & ~data_dly_q;
        EDGE_FALL: edge_s = ~data_sync & data_dly_q;
        EDGE_ANY:  edge_s = data_sync ^ data_dly_q;
        default:   edge_s = data_sync & ~data_dly_q;
      endcase
    end else begin
      edge_s = '0;
    end
  end

  // Register-write decode; a new edge overrides a simultaneous clear
  always_comb begin
    clr_s     = '0;
    irqmask_d = irqmask_q;
    if (wr_s && (address == ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_s && (address == ADDR_MASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end
    edgecap_d = (edgecap_q & ~clr_s) | edge_s;
  end

  // Read mux, registered every clock irrespective of chipselect
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = data_sync;
      ADDR_RSVD: readdata_d            = 32'd0;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
      default:   readdata_d            = 32'd0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      data_dly_q <= '0;
      armed_q    <= 1'b0;
      valid_q    <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= 32'd0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      data_dly_q <= data_sync;
      armed_q    <= 1'b1;
      valid_q    <= {valid_q[SYNC_STAGES-1:1], armed_q};
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
